// File: rtl/addsub_pkg.sv
// Shared constants and parameter legality check for the pipelined adder/subtractor.
package addsub_pkg;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  // Legal when the width splits evenly into 1..width slices.
  function automatic bit width_ok(input int unsigned width, input int unsigned stages);
    return (stages >= 1) && (stages <= width) && ((width % stages) == 0);
  endfunction

endpackage

// File: rtl/addsub_slice.sv
// Combinational SW-bit adder slice with carry in/out; one per pipeline stage.
module addsub_slice #(
  parameter int unsigned SW = 4
) (
  input  logic [SW-1:0] a,
  input  logic [SW-1:0] b,
  input  logic          ci,
  output logic [SW-1:0] s,
  output logic          co
);

  localparam int unsigned SWP1 = SW + 1;

  logic [SW:0] w_sum;

  assign w_sum = SWP1'(a) + SWP1'(b) + SWP1'(ci);
  assign s     = w_sum[SW-1:0];
  assign co    = w_sum[SW];

endmodule

// File: rtl/pipelined_addsub.sv
// Pipelined WIDTH-bit adder/subtractor: one SW-bit slice per stage, carry registered
// between stages, valid/ready on both sides with a single global advance enable.
module pipelined_addsub
  import addsub_pkg::*;
#(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             Sub,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] Z,
  output logic             Cout,
  output logic             Ovf,
  output logic             Zero,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int unsigned SW  = WIDTH / STAGES;
  localparam int unsigned MSB = WIDTH - 1;

  if (!width_ok(WIDTH, STAGES)) begin : g_bad_params
    $error("pipelined_addsub: WIDTH must be a multiple of STAGES and STAGES in 1..WIDTH");
  end

  logic                          w_adv;
  logic [WIDTH-1:0]              w_b_eff;
  logic                          w_cin_eff;
  logic [STAGES-1:0][WIDTH-1:0]  w_a_in;
  logic [STAGES-1:0][WIDTH-1:0]  w_b_in;
  logic [STAGES-1:0][WIDTH-1:0]  w_z_in;
  logic [STAGES-1:0][WIDTH-1:0]  w_z_nxt;
  logic [STAGES-1:0]             w_c_in;
  logic [STAGES-1:0]             w_co;
  logic [STAGES-1:0][SW-1:0]     w_s;
  logic [WIDTH-1:0]              w_z_fin;
  logic                          w_ovf;
  logic                          w_zero;
  logic                          w_unused_ops;

  logic [STAGES-1:0]             r_vld;
  logic [STAGES-1:0][WIDTH-1:0]  r_a;
  logic [STAGES-1:0][WIDTH-1:0]  r_b;
  logic [STAGES-1:0][WIDTH-1:0]  r_z;
  logic [STAGES-1:0]             r_c;
  logic                          r_ovf;
  logic                          r_zero;

  // Whole pipeline moves together; bubbles shift too, so only the output end can stall it.
  assign w_adv     = !r_vld[STAGES-1] || out_ready;
  assign in_ready  = w_adv;
  assign w_b_eff   = (Sub == MODE_SUB) ? ~B : B;
  assign w_cin_eff = (Sub == MODE_SUB) ? ~Cin : Cin;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    if (k == 0) begin : g_first
      assign w_a_in[k] = A;
      assign w_b_in[k] = w_b_eff;
      assign w_c_in[k] = w_cin_eff;
      assign w_z_in[k] = '0;
    end else begin : g_next
      assign w_a_in[k] = r_a[k-1];
      assign w_b_in[k] = r_b[k-1];
      assign w_c_in[k] = r_c[k-1];
      assign w_z_in[k] = r_z[k-1];
    end

    addsub_slice #(.SW(SW)) u_slice (
      .a  (w_a_in[k][k*SW +: SW]),
      .b  (w_b_in[k][k*SW +: SW]),
      .ci (w_c_in[k]),
      .s  (w_s[k]),
      .co (w_co[k])
    );

    // Slices at and above k are still zero, so OR-ing places this stage's sum.
    assign w_z_nxt[k] = w_z_in[k] | (WIDTH'(w_s[k]) << (k * SW));
  end

  assign w_z_fin = w_z_nxt[STAGES-1];
  assign w_ovf   = (w_a_in[STAGES-1][MSB] == w_b_in[STAGES-1][MSB]) &&
                   (w_z_fin[MSB] != w_a_in[STAGES-1][MSB]);
  assign w_zero  = (w_z_fin == '0);

  // Last stage's operand copies have no consumer.
  assign w_unused_ops = ^{r_a[STAGES-1], r_b[STAGES-1]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld  <= '0;
      r_a    <= '0;
      r_b    <= '0;
      r_z    <= '0;
      r_c    <= '0;
      r_ovf  <= 1'b0;
      r_zero <= 1'b0;
    end else if (w_adv) begin
      r_vld  <= (r_vld << 1) | STAGES'(in_valid);
      r_a    <= w_a_in;
      r_b    <= w_b_in;
      r_z    <= w_z_nxt;
      r_c    <= w_co;
      r_ovf  <= w_ovf;
      r_zero <= w_zero;
    end
  end

  assign Z         = r_z[STAGES-1];
  assign Cout      = r_c[STAGES-1];
  assign Ovf       = r_ovf;
  assign Zero      = r_zero;
  assign out_valid = r_vld[STAGES-1];

endmodule
